// File: rtl/i2s_pkg.sv
// Shared types for the I2S capture path: default word width, receiver states and the
// stereo frame that travels from the serial assembler into the frame buffer.
package i2s_pkg;

    localparam int I2S_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT
    } rx_state_e;

    typedef struct packed {
        logic [I2S_DATA_W-1:0] left;
        logic [I2S_DATA_W-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Circular stereo-frame buffer for the I2S receiver; pointers carry one extra wrap bit
// so full and empty are told apart. A push into a full buffer is accepted only when a pop happens in the same cycle.
module i2s_rx_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push_i,
    input  stereo_frame_t pushData_i,
    input  logic          pop_i,
    output stereo_frame_t popData_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    stereo_frame_t mem_q [DEPTH];
    logic [PTR_W:0] wrPtr_q;
    logic [PTR_W:0] rdPtr_q;
    logic           doPush;
    logic           doPop;

    assign empty_o   = (wrPtr_q == rdPtr_q);
    assign full_o    = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                       (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign doPop     = pop_i && !empty_o;
    assign doPush    = push_i && (!full_o || doPop);
    assign popData_o = mem_q[rdPtr_q[PTR_W-1:0]];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q[PTR_W-1:0]] <= pushData_i;
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes codec SCLK/LRCLK/Din into CLK, assembles left/right words and
// queues stereo frames. Define I2S_RX_FIFO_EN for a FIFO_DEPTH frame buffer, else one holding register.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W     = I2S_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCLK,
    input  logic              LRCLK,
    input  logic              Din,
    input  logic              enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              overflow,
    output logic              frame_err,
    input  logic              status_clr
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]        sclkSync_q;
    logic [1:0]        lrSync_q;
    logic [1:0]        dinSync_q;
    logic              lrPrev_q;
    rx_state_e         state_q;
    logic              chan_q;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] leftStage_q;
    stereo_frame_t     commitFrame_q;
    logic              commitValid_q;
    logic              frameErr_q;
    logic              overflow_q;

    logic              sclkRise;
    logic              lrNow;
    logic              dinNow;
    logic              lrChange;
    logic              wordEnd;
    logic [DATA_W-1:0] shiftNext;
    logic [DATA_W-1:0] wordDone;
    logic              bufFull;
    logic              bufEmpty;
    logic              pop;
    logic              dropFrame;
    stereo_frame_t     headFrame;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sclkSync_q <= '0;
            lrSync_q   <= '0;
            dinSync_q  <= '0;
        end else begin
            sclkSync_q <= {sclkSync_q[1:0], SCLK};
            lrSync_q   <= {lrSync_q[0], LRCLK};
            dinSync_q  <= {dinSync_q[0], Din};
        end
    end

    assign sclkRise = sclkSync_q[1] & ~sclkSync_q[2];
    assign lrNow    = lrSync_q[1];
    assign dinNow   = dinSync_q[1];
    assign lrChange = (lrNow != lrPrev_q);
    assign wordEnd  = enable && sclkRise && (state_q == SHIFT) &&
                      (lrChange || (bitCnt_q == LAST_BIT));

    // A slot cut short by an LRCLK edge keeps its bits MSB-aligned with zero fill below.
    always_comb begin
        shiftNext = {shift_q[DATA_W-2:0], dinNow};
        wordDone  = lrChange ? (shift_q << (FULL_CNT - bitCnt_q)) : shiftNext;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lrPrev_q      <= 1'b0;
            state_q       <= IDLE;
            chan_q        <= 1'b0;
            bitCnt_q      <= '0;
            shift_q       <= '0;
            leftStage_q   <= '0;
            commitFrame_q <= '0;
            commitValid_q <= 1'b0;
            frameErr_q    <= 1'b0;
        end else begin
            commitValid_q <= 1'b0;
            if (sclkRise) begin
                lrPrev_q <= lrNow;
            end
            if (status_clr) begin
                frameErr_q <= 1'b0;
            end else if (wordEnd && lrChange) begin
                frameErr_q <= 1'b1;
            end
            if (wordEnd) begin
                if (!chan_q) begin
                    leftStage_q <= wordDone;
                end else begin
                    commitFrame_q <= '{left: leftStage_q, right: wordDone};
                    commitValid_q <= 1'b1;
                end
            end
            if (!enable) begin
                state_q <= IDLE;
            end else if (sclkRise) begin
                case (state_q)
                    IDLE: begin
                        if (lrPrev_q && !lrNow) begin
                            state_q  <= SHIFT;
                            chan_q   <= 1'b0;
                            bitCnt_q <= '0;
                            shift_q  <= '0;
                        end
                    end
                    SHIFT: begin
                        if (lrChange) begin
                            chan_q   <= lrNow;
                            bitCnt_q <= '0;
                            shift_q  <= '0;
                        end else begin
                            shift_q  <= shiftNext;
                            bitCnt_q <= bitCnt_q + CNT_ONE;
                            if (bitCnt_q == LAST_BIT) begin
                                state_q <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (lrChange) begin
                            state_q  <= SHIFT;
                            chan_q   <= lrNow;
                            bitCnt_q <= '0;
                            shift_q  <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pop       = !bufEmpty && out_ready;
    assign dropFrame = commitValid_q && bufFull && !pop;

`ifdef I2S_RX_FIFO_EN
    i2s_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) uFifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push_i     (commitValid_q),
        .pushData_i (commitFrame_q),
        .pop_i      (pop),
        .popData_o  (headFrame),
        .full_o     (bufFull),
        .empty_o    (bufEmpty)
    );
`else
    stereo_frame_t hold_q;
    logic          holdValid_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_q      <= '0;
            holdValid_q <= 1'b0;
        end else if (commitValid_q && (!holdValid_q || pop)) begin
            hold_q      <= commitFrame_q;
            holdValid_q <= 1'b1;
        end else if (pop) begin
            holdValid_q <= 1'b0;
        end
    end

    assign headFrame = hold_q;
    assign bufFull   = holdValid_q;
    assign bufEmpty  = !holdValid_q;

    // The holding register always stores exactly one frame, so the depth has nothing to size here.
    if (FIFO_DEPTH < 2) begin : gDepthUnused
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            overflow_q <= 1'b0;
        end else if (status_clr) begin
            overflow_q <= 1'b0;
        end else if (dropFrame) begin
            overflow_q <= 1'b1;
        end
    end

    assign out_valid = !bufEmpty;
    assign out_left  = headFrame.left;
    assign out_right = headFrame.right;
    assign overflow  = overflow_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed/randomized bench for i2s_rx: plays I2S frames bit by bit and compares delivered
// frames against a queue of frames predicted from what was transmitted.
`timescale 1ns/1ps
module tb_i2s_rx;
    localparam int DW   = 24;
    localparam int HALF = 50;
`ifdef I2S_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          SCLK = 1'b0;
    logic          LRCLK = 1'b1;
    logic          Din = 1'b0;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic          status_clr = 1'b0;
    logic          out_valid;
    logic          overflow;
    logic          frame_err;
    logic [DW-1:0] out_left;
    logic [DW-1:0] out_right;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lsbCyc = 0;
    int validCyc = 0;
    logic [2*DW-1:0] gotQ[$];
    logic [2*DW-1:0] expQ[$];

    i2s_rx #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SCLK       (SCLK),
        .LRCLK      (LRCLK),
        .Din        (Din),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_left   (out_left),
        .out_right  (out_right),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .status_clr (status_clr)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    always @(posedge out_valid) validCyc = cyc;

    // A frame is transferred on the next rising edge whenever valid and ready are both high mid-cycle.
    always @(negedge CLK) begin
        if (!RESET && out_valid && out_ready) gotQ.push_back({out_left, out_right});
    end

    task automatic checkOutput(input string tag, input logic [2*DW-1:0] observed,
                               input logic [2*DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clockBit(input logic lr, input logic d, input bit markLsb, input bit popOnCommit);
        time riseT;
        LRCLK = lr;
        Din   = d;
        #HALF;
        SCLK  = 1'b1;
        riseT = $time;
        if (markLsb) lsbCyc = cyc;
        if (popOnCommit) begin
            repeat (3) @(posedge CLK);
            #2 out_ready = 1'b1;
            @(posedge CLK);
            #2 out_ready = 1'b0;
            #(HALF - ($time - riseT));
        end else begin
            #HALF;
        end
        SCLK = 1'b0;
    endtask

    // One LRCLK slot: delay bit, dataBits MSB-first, zero padding up to slotLen.
    task automatic applyStimulus(input logic lr, input logic [DW-1:0] data, input int dataBits,
                                 input int slotLen, input bit popOnCommit);
        logic d;
        bit   last;
        for (int i = 0; i < slotLen; i++) begin
            d = 1'b0;
            if (i >= 1 && i <= dataBits) d = data[dataBits - i];
            last = (lr == 1'b1) && (i == dataBits);
            clockBit(lr, d, last, last && popOnCommit);
        end
    endtask

    task automatic sendFrame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int bits,
                             input int slotLen, input bit popOnCommit);
        applyStimulus(1'b0, l, bits, slotLen, 1'b0);
        applyStimulus(1'b1, r, bits, slotLen, popOnCommit);
    endtask

    function automatic logic [DW-1:0] leftJustify(input logic [DW-1:0] data, input int bits);
        return (bits >= DW) ? data : (data << (DW - bits));
    endfunction

    task automatic setReady(input logic v);
        @(posedge CLK);
        #2 out_ready = v;
    endtask

    task automatic pulseClear();
        @(posedge CLK);
        #2 status_clr = 1'b1;
        @(posedge CLK);
        #2 status_clr = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && gotQ.size() < expQ.size(); i++) @(posedge CLK);
        @(posedge CLK);
        #2;
    endtask

    task automatic compareQueues(input string tag);
        logic [2*DW-1:0] got;
        checkOutput({tag, "_count"}, 48'(gotQ.size()), 48'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < gotQ.size()) ? gotQ[i] : 'x;
            checkOutput($sformatf("%s_frame%0d", tag, i), got, expQ[i]);
        end
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic sendRandom(input bit keep);
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        l = DW'($urandom);
        r = DW'($urandom);
        sendFrame(l, r, DW, 32, 1'b0);
        if (keep) expQ.push_back({l, r});
    endtask

    initial begin
        logic [DW-1:0] l;
        logic [DW-1:0] r;

        #12;
        checkOutput("rst_valid", 48'(out_valid), 48'd0);
        checkOutput("rst_left", 48'(out_left), 48'd0);
        checkOutput("rst_right", 48'(out_right), 48'd0);
        checkOutput("rst_overflow", 48'(overflow), 48'd0);
        checkOutput("rst_frame_err", 48'(frame_err), 48'd0);

        @(posedge CLK);
        #2 RESET = 1'b0;
        enable = 1'b1;
        setReady(1'b1);

        // Capture starts mid-right-slot: those bits must never appear.
        for (int i = 0; i < 15; i++) clockBit(1'b1, 1'($urandom), 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            sendFrame(24'hA50F3C, 24'h123456, DW, 32, 1'b0);
            expQ.push_back({24'hA50F3C, 24'h123456});
        end
        for (int i = 0; i < 3; i++) sendRandom(1'b1);
        waitDrain();
        compareQueues("basic");
        checkOutput("latency", 48'(validCyc - lsbCyc), 48'd4);
        checkOutput("basic_overflow", 48'(overflow), 48'd0);
        checkOutput("basic_frame_err", 48'(frame_err), 48'd0);

        setReady(1'b0);
        for (int i = 0; i < 5; i++) sendRandom(i < CAP);
        checkOutput("ovf_set", 48'(overflow), 48'd1);
        pulseClear();
        checkOutput("ovf_clear", 48'(overflow), 48'd0);
        setReady(1'b1);
        waitDrain();
        compareQueues("overflow");

        setReady(1'b0);
        for (int i = 0; i < CAP; i++) sendRandom(1'b1);
        l = DW'($urandom);
        r = DW'($urandom);
        sendFrame(l, r, DW, 32, 1'b1);
        expQ.push_back({l, r});
        checkOutput("pushpop_popped", 48'(gotQ.size()), 48'd1);
        checkOutput("pushpop_overflow", 48'(overflow), 48'd0);
        setReady(1'b1);
        waitDrain();
        compareQueues("pushpop");

        r = {8'h00, 16'($urandom)};
        sendFrame(24'h00BEEF, r, 16, 17, 1'b0);
        expQ.push_back({leftJustify(24'h00BEEF, 16), leftJustify(r, 16)});
        sendRandom(1'b1);
        checkOutput("short_frame_err", 48'(frame_err), 48'd1);
        waitDrain();
        compareQueues("short");
        pulseClear();
        checkOutput("short_err_clear", 48'(frame_err), 48'd0);

        l = DW'($urandom);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) enable = 1'b0;
            if (i == 14) enable = 1'b1;
            clockBit(1'b0, (i >= 1 && i <= DW) ? l[DW - i] : 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, DW'($urandom), DW, 32, 1'b0);
        sendRandom(1'b1);
        waitDrain();
        compareQueues("enable");

        for (int i = 0; i < 12; i++) clockBit(1'b0, 1'($urandom), 1'b0, 1'b0);
        RESET = 1'b1;
        #1;
        checkOutput("midrst_valid", 48'(out_valid), 48'd0);
        @(posedge CLK);
        #2 RESET = 1'b0;
        for (int i = 0; i < 20; i++) clockBit(1'b0, 1'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, DW'($urandom), DW, 32, 1'b0);
        sendRandom(1'b1);
        waitDrain();
        compareQueues("midrst");
        checkOutput("midrst_flags", {46'd0, overflow, frame_err}, 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
